// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: one shared BCD decoder, blanking gap
// between digits, double-buffered digit values and optional leading-zero blanking.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    w_clk,
  input  logic                    w_rst_n,
  input  logic                    w_enable,
  input  logic [4*NUM_DIGITS-1:0] w_digits,
  input  logic [NUM_DIGITS-1:0]   w_dp_mask,
  input  logic                    w_lzb,
  input  logic                    w_load,
  input  logic [6:0]              w_seg7,
  output logic [3:0]              w_bcd,
  output logic [6:0]              w_seg_out,
  output logic                    w_dp,
  output logic [NUM_DIGITS-1:0]   w_dig_en,
  output logic                    w_frame_tick
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic                    frame_start;

  logic [4*NUM_DIGITS-1:0] act_digits, act_digits_nxt;
  logic [NUM_DIGITS-1:0]   act_dp, act_dp_nxt;
  logic [4*NUM_DIGITS-1:0] pend_digits, pend_digits_nxt;
  logic [NUM_DIGITS-1:0]   pend_dp, pend_dp_nxt;
  logic                    pend_valid, pend_valid_nxt;

  logic [3:0]              bcd_nxt;
  logic [6:0]              seg_nxt;
  logic                    dp_nxt;
  logic [NUM_DIGITS-1:0]   dig_en_nxt;

  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    zero_above;

  // Digit k is a leading zero when it and every more-significant active nibble are 0.
  always_comb begin
    blank_mask = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above    = zero_above && (act_digits[4*k +: 4] == 4'd0);
      blank_mask[k] = w_lzb && zero_above;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt       = state;
    idx_nxt         = idx;
    cnt_nxt         = cnt;
    frame_start     = 1'b0;
    act_digits_nxt  = act_digits;
    act_dp_nxt      = act_dp;
    pend_digits_nxt = pend_digits;
    pend_dp_nxt     = pend_dp;
    pend_valid_nxt  = pend_valid;
    bcd_nxt         = w_bcd;
    seg_nxt         = w_seg_out;
    dp_nxt          = w_dp;
    dig_en_nxt      = w_dig_en;

    if (!w_enable) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt   = BLANK;
          idx_nxt     = '0;
          cnt_nxt     = '0;
          frame_start = 1'b1;
        end
        BLANK: begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == CNT_W'(BLANK_CYCLES - 1)) state_nxt = SHOW;
        end
        SHOW: begin
          if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
            if (idx == IDX_W'(NUM_DIGITS - 1)) begin
              idx_nxt     = '0;
              frame_start = 1'b1;
            end else begin
              idx_nxt = idx + 1'b1;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
      endcase
    end

    // Active buffer only changes at a frame start, so a frame never mixes two values.
    if (frame_start) begin
      if (w_load) begin
        act_digits_nxt = w_digits;
        act_dp_nxt     = w_dp_mask;
        pend_valid_nxt = 1'b0;
      end else if (pend_valid) begin
        act_digits_nxt = pend_digits;
        act_dp_nxt     = pend_dp;
        pend_valid_nxt = 1'b0;
      end
    end else if (w_load) begin
      pend_digits_nxt = w_digits;
      pend_dp_nxt     = w_dp_mask;
      pend_valid_nxt  = 1'b1;
    end

    if (state_nxt == IDLE) begin
      bcd_nxt    = 4'd0;
      seg_nxt    = 7'd0;
      dp_nxt     = 1'b0;
      dig_en_nxt = '0;
    end else if (state_nxt == BLANK && state != BLANK) begin
      bcd_nxt    = act_digits_nxt[4*int'(idx_nxt) +: 4];
      seg_nxt    = 7'd0;
      dp_nxt     = 1'b0;
      dig_en_nxt = '0;
    end else if (state_nxt == SHOW && state == BLANK) begin
      // w_seg7 is the decoder's answer to the nibble presented since slot start.
      dig_en_nxt = NUM_DIGITS'(1) << idx;
      seg_nxt    = blank_mask[idx] ? 7'd0 : w_seg7;
      dp_nxt     = act_dp[idx];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  // The digit buffers are reset too: after reset the display must show zeros, not garbage.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      cnt          <= '0;
      act_digits   <= '0;
      act_dp       <= '0;
      pend_digits  <= '0;
      pend_dp      <= '0;
      pend_valid   <= 1'b0;
      w_bcd        <= 4'd0;
      w_seg_out    <= 7'd0;
      w_dp         <= 1'b0;
      w_dig_en     <= '0;
      w_frame_tick <= 1'b0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      cnt          <= cnt_nxt;
      act_digits   <= act_digits_nxt;
      act_dp       <= act_dp_nxt;
      pend_digits  <= pend_digits_nxt;
      pend_dp      <= pend_dp_nxt;
      pend_valid   <= pend_valid_nxt;
      w_bcd        <= bcd_nxt;
      w_seg_out    <= seg_nxt;
      w_dp         <= dp_nxt;
      w_dig_en     <= dig_en_nxt;
      w_frame_tick <= frame_start;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: table-driven frames, directed corner
// sequences and random traffic against a time-based reference model.
module tb_seg7_scan_ctrl;

  localparam int N = 4;
  localparam int R = 8;
  localparam int B = 2;

  logic           w_clk = 1'b0;
  logic           w_rst_n;
  logic           w_enable;
  logic [4*N-1:0] w_digits;
  logic [N-1:0]   w_dp_mask;
  logic           w_lzb;
  logic           w_load;
  logic [6:0]     w_seg7;
  logic [3:0]     w_bcd;
  logic [6:0]     w_seg_out;
  logic           w_dp;
  logic [N-1:0]   w_dig_en;
  logic           w_frame_tick;

  int n_cmp = 0;
  int n_bad = 0;

  seg7_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .w_clk        (w_clk),
    .w_rst_n      (w_rst_n),
    .w_enable     (w_enable),
    .w_digits     (w_digits),
    .w_dp_mask    (w_dp_mask),
    .w_lzb        (w_lzb),
    .w_load       (w_load),
    .w_seg7       (w_seg7),
    .w_bcd        (w_bcd),
    .w_seg_out    (w_seg_out),
    .w_dp         (w_dp),
    .w_dig_en     (w_dig_en),
    .w_frame_tick (w_frame_tick)
  );

  always #5 w_clk = ~w_clk;

  function automatic logic [6:0] dec(input logic [3:0] v);
    case (v)
      4'h0: dec = 7'h7E;  4'h1: dec = 7'h30;  4'h2: dec = 7'h6D;  4'h3: dec = 7'h79;
      4'h4: dec = 7'h33;  4'h5: dec = 7'h5B;  4'h6: dec = 7'h5F;  4'h7: dec = 7'h70;
      4'h8: dec = 7'h7F;  4'h9: dec = 7'h7B;  4'hA: dec = 7'h77;  4'hB: dec = 7'h1F;
      4'hC: dec = 7'h4E;  4'hD: dec = 7'h3D;  4'hE: dec = 7'h4F;  default: dec = 7'h47;
    endcase
  endfunction

  assign w_seg7 = dec(w_bcd);

  // Reference model: position in the scan is a single time count since the frame start.
  bit             m_on;
  int             m_t;
  logic [4*N-1:0] m_act, m_pend;
  logic [N-1:0]   m_act_dp, m_pend_dp;
  bit             m_pv;
  logic [3:0]     e_bcd;
  logic [6:0]     e_seg;
  logic           e_dp, e_tick;
  logic [N-1:0]   e_en;

  task automatic model_reset();
    m_on = 0; m_t = 0; m_pv = 0;
    m_act = '0; m_pend = '0; m_act_dp = '0; m_pend_dp = '0;
    e_bcd = '0; e_seg = '0; e_dp = 0; e_tick = 0; e_en = '0;
  endtask

  task automatic model_step();
    bit fs;
    int dig, ph;
    bit blanked;
    logic [4*N-1:0] upper;
    fs = 0;
    if (!w_enable) m_on = 0;
    else if (!m_on) begin m_on = 1; m_t = 0; fs = 1; end
    else begin m_t = (m_t + 1) % (R * N); fs = (m_t == 0); end

    if (fs) begin
      if (w_load) begin m_act = w_digits; m_act_dp = w_dp_mask; m_pv = 0; end
      else if (m_pv) begin m_act = m_pend; m_act_dp = m_pend_dp; m_pv = 0; end
    end else if (w_load) begin
      m_pend = w_digits; m_pend_dp = w_dp_mask; m_pv = 1;
    end

    if (!m_on) begin
      e_bcd = '0; e_seg = '0; e_dp = 0; e_tick = 0; e_en = '0;
    end else begin
      dig    = m_t / R;
      ph     = m_t % R;
      e_tick = fs;
      upper  = m_act >> (4 * dig);
      e_bcd  = upper[3:0];
      if (ph < B) begin
        e_en = '0; e_seg = '0; e_dp = 0;
      end else if (ph == B) begin
        blanked = w_lzb && (dig >= 1) && (upper == '0);
        e_en    = N'(1) << dig;
        e_seg   = blanked ? 7'd0 : dec(e_bcd);
        e_dp    = m_act_dp[dig];
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("bcd",        32'(w_bcd),        32'(e_bcd));
    check("seg_out",    32'(w_seg_out),    32'(e_seg));
    check("dp",         32'(w_dp),         32'(e_dp));
    check("dig_en",     32'(w_dig_en),     32'(e_en));
    check("frame_tick", 32'(w_frame_tick), 32'(e_tick));
  endtask

  task automatic cycle();
    @(posedge w_clk);
    model_step();
    #1;
    check_outputs();
  endtask

  function automatic logic [4*N-1:0] rnd_digits();
    logic [4*N-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++)
      if ($urandom_range(0, 1) == 1) v[4*k +: 4] = 4'($urandom_range(0, 15));
    return v;
  endfunction

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        lzb;
    logic [27:0] segs;  // {digit3, digit2, digit1, digit0}
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{16'h1234, 4'b0000, 1'b0, {7'h30, 7'h6D, 7'h79, 7'h33}};
    tbl[1] = '{16'h0070, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h70, 7'h7E}};
    tbl[2] = '{16'h0070, 4'b0000, 1'b0, {7'h7E, 7'h7E, 7'h70, 7'h7E}};
    tbl[3] = '{16'hABCD, 4'b0101, 1'b0, {7'h77, 7'h1F, 7'h4E, 7'h3D}};
    tbl[4] = '{16'h0000, 4'b1100, 1'b1, {7'h00, 7'h00, 7'h00, 7'h7E}};
    tbl[5] = '{16'h1000, 4'b0010, 1'b1, {7'h30, 7'h7E, 7'h7E, 7'h7E}};

    w_rst_n = 0; w_enable = 0; w_digits = '0; w_dp_mask = '0; w_lzb = 0; w_load = 0;
    model_reset();
    #12;
    check("reset_state", {w_bcd, w_seg_out, w_dp, w_dig_en, w_frame_tick}, 32'd0);
    w_rst_n = 1;

    // Table-driven frames: load while idle, enable, inspect every digit's SHOW phase.
    for (int i = 0; i < 6; i++) begin
      w_enable = 0;
      cycle();
      w_digits = tbl[i].digits; w_dp_mask = tbl[i].dp; w_lzb = tbl[i].lzb; w_load = 1;
      cycle();
      w_load = 0; w_enable = 1;
      cycle();
      check("tbl_tick", 32'(w_frame_tick), 32'd1);
      for (int t = 1; t < R * N; t++) begin
        cycle();
        if (t % R == B) begin
          check("tbl_seg", 32'(w_seg_out), 32'(tbl[i].segs[7*(t/R) +: 7]));
          check("tbl_en",  32'(w_dig_en),  32'(N'(1) << (t / R)));
          check("tbl_dp",  32'(w_dp),      32'(tbl[i].dp[t/R]));
        end
      end
    end

    // Load mid-frame: current frame keeps old value, next frame shows the new one.
    w_enable = 0; w_lzb = 0;
    cycle();
    w_digits = 16'h1234; w_dp_mask = '0; w_load = 1;
    cycle();
    w_load = 0; w_enable = 1;
    cycle();
    repeat (R + B) cycle();
    w_digits = 16'h5678; w_load = 1;
    cycle();
    w_load = 0; w_digits = '0;
    repeat (R) cycle();
    check("midload_old_d2", 32'(w_bcd), 32'd2);
    repeat (2 * R - B - 1) cycle();
    check("midload_tick", 32'(w_frame_tick), 32'd1);
    check("midload_new_d0", 32'(w_bcd), 32'd8);

    // Load on the frame-start edge goes straight into the frame being started.
    repeat (R * N - 1) cycle();
    w_digits = 16'h9999; w_load = 1;
    cycle();
    w_load = 0; w_digits = '0;
    check("bypass_tick", 32'(w_frame_tick), 32'd1);
    check("bypass_d0", 32'(w_bcd), 32'd9);
    for (int k = 1; k < N; k++) begin
      repeat (R) cycle();
      check("bypass_dk", 32'(w_bcd), 32'd9);
    end

    // Enable dropped while digit 2 is showing, then re-enabled.
    repeat (R) cycle();
    repeat (2 * R + B + 1) cycle();
    check("drop_pre_en", 32'(w_dig_en), 32'b0100);
    w_enable = 0;
    cycle();
    check("drop_off", {w_bcd, w_seg_out, w_dp, w_dig_en, w_frame_tick}, 32'd0);
    w_enable = 1;
    cycle();
    check("reen_tick", 32'(w_frame_tick), 32'd1);
    check("reen_d0", 32'(w_bcd), 32'd9);

    // Asynchronous reset mid-SHOW, between clock edges.
    repeat (B + 1) cycle();
    check("prerst_en", 32'(w_dig_en), 32'b0001);
    w_rst_n = 0; w_enable = 0;
    #2;
    check("async_rst", {w_bcd, w_seg_out, w_dp, w_dig_en, w_frame_tick}, 32'd0);
    model_reset();
    #2;
    w_rst_n = 1;
    repeat (3) cycle();
    check("rst_idle", 32'(w_dig_en), 32'd0);
    w_enable = 1;
    cycle();
    check("rst_reen_tick", 32'(w_frame_tick), 32'd1);
    check("rst_bufs_zero", 32'(w_bcd), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      w_load = ($urandom_range(0, 7) == 0);
      if (w_load) begin
        w_digits  = rnd_digits();
        w_dp_mask = N'($urandom_range(0, 15));
      end
      w_enable = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 15) == 0) w_lzb = ~w_lzb;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller for the decade clock's multi-digit 7-segment display.
- Shares one external 4-bit-to-7-segment decoder among NUM_DIGITS digits: drives one BCD nibble at a time, captures the decoded segment pattern, and strobes a single digit enable.
- Inserts a blanking interval between digits to suppress ghosting.
- Double-buffers the digit values so an update never tears mid-frame.
- Sits between the clock counters (digit source) and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- REFRESH_DIV, 50000, clock cycles per digit slot; must be > BLANK_CYCLES.
- BLANK_CYCLES, 500, cycles at the start of each slot with all digits off; must be >= 1.

Ports:
- w_clk  in  1  system clock
- w_rst_n  in  1  asynchronous, active-low reset
- w_enable  in  1  scanning enabled; low forces display off
- w_digits  in  4*NUM_DIGITS  digit values; nibble k = digit k, digit 0 rightmost
- w_dp_mask  in  NUM_DIGITS  decimal point per digit
- w_lzb  in  1  leading-zero blanking enable
- w_load  in  1  one-cycle pulse; captures w_digits and w_dp_mask into pending buffer
- w_seg7  in  7  decoded pattern returned from shared decoder (combinational from w_bcd)
- w_bcd  out  4  nibble to shared decoder
- w_seg_out  out  7  segment drive to display, active-high, bit 6 = a
- w_dp  out  1  decimal point drive
- w_dig_en  out  NUM_DIGITS  one-hot digit enable, active-high
- w_frame_tick  out  1  one-cycle pulse at each frame start

Behaviour:
- All outputs are registered.
- Reset (async on w_rst_n low): every output = 0; pending and active buffers = 0; pend_valid = 0; state = IDLE; idx = 0; cnt = 0.
- States: IDLE, BLANK, SHOW.
- IDLE: w_dig_en = 0, w_seg_out = 0, w_dp = 0. If w_enable = 1, next edge goes to BLANK with idx = 0, cnt = 0 (a frame start).
- Frame start (entry to BLANK with idx = 0):
  - w_frame_tick = 1 for that cycle.
  - If pend_valid, then active <= pending and pend_valid <= 0.
  - If w_load = 1 on the same edge, active takes w_digits/w_dp_mask directly (bypass), and pend_valid stays 0.
- w_load at any other time: pending <= inputs, pend_valid <= 1. Repeated loads overwrite pending; only the last one before a frame start is shown.
- BLANK entry: w_bcd <= active nibble[idx]. During BLANK, w_dig_en = 0, w_seg_out = 0, w_dp = 0. The state lasts exactly BLANK_CYCLES cycles.
- BLANK -> SHOW on the edge where cnt reaches BLANK_CYCLES-1. On that edge:
  - w_dig_en <= one-hot(idx);
  - w_seg_out <= w_seg7, or 0 if blanked;
  - w_dp <= dp[idx].
- SHOW lasts REFRESH_DIV-BLANK_CYCLES cycles. Outputs are held stable; w_bcd is unchanged.
- At the end of SHOW, go to BLANK with idx <= idx+1. Wrap from NUM_DIGITS-1 to 0, which is a frame start. cnt restarts at 0 on each slot; one slot = REFRESH_DIV cycles.
- Leading-zero blanking: with w_lzb = 1, digit k (k >= 1) is blanked when active nibbles k..NUM_DIGITS-1 are all 0.
  - Digit 0 is never blanked.
  - A blanked digit keeps w_dig_en asserted, but w_seg_out = 0 and w_dp = dp[idx].
- w_enable falling in any state: next edge forces IDLE, outputs cleared, idx = cnt = 0. Buffers are retained. Re-enable restarts at a frame start.
- Nibble values 10..15 are passed to the decoder unchanged (hex display permitted).
- Reset asserted mid-slot: immediate clear per reset values. No partial frame resumes.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2):
- Reset, enable, load 0x1234 before enable -> w_frame_tick 1 cycle after enable. w_bcd sequence 4,3,2,1 per 8-cycle slot. w_dig_en 0001/0010/0100/1000, each high 6 cycles after 2 zero cycles. w_seg_out matches w_seg7 for each nibble; frame period 32 cycles.
- Load 0x5678 mid-frame (digit 1 showing) -> remaining digits of the current frame still show 1234; next frame shows 8,7,6,5.
- w_load coincident with frame-start edge carrying 0x9999 -> that same frame shows 9 on all digits.
- w_lzb=1, value 0x0070 -> digits 3 and 2 have w_seg_out=0000000 with w_dig_en still asserted. Digit 1 shows 7. Digit 0 shows 0 (1111110 from the decoder model).
- w_enable dropped during SHOW of digit 2 -> next cycle all outputs 0. Re-enable -> frame_tick, restart at digit 0.
- Async reset pulse mid-SHOW (no clock edge) -> outputs 0 immediately. After release, remains IDLE until w_enable is sampled high.
